// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core (lw, sw, add/sub/and/or/slt, addi, beq, j) sharing one
// instruction/data memory port; a control FSM sequences each instruction.
module mips_multicycle_core #(
  parameter int                    Data_Width     = 32,
  parameter int                    Reg_Addr_Width = 5,
  parameter logic [Data_Width-1:0] Reset_Vector   = '0,
  parameter int                    Count_Width    = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  output logic                   Mem_Req,
  output logic                   Mem_WE,
  output logic [Data_Width-1:0]  Mem_Addr,
  output logic [Data_Width-1:0]  Mem_WData,
  input  logic [Data_Width-1:0]  Mem_RData,
  input  logic                   Mem_Ready,
  output logic [Count_Width-1:0] Instr_Retired,
  output logic                   Illegal_Op,
  output logic [3:0]             dbg_state
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
  } state_t;

  state_t                  state;
  logic [Data_Width-1:0]   pc, a_q, b_q, alu_out, mdr;
  logic [31:0]             ir;
  logic [Count_Width-1:0]  retired;
  logic [Data_Width-1:0]   rf [2**Reg_Addr_Width];

  logic [5:0]                op;
  logic [Reg_Addr_Width-1:0] rs_idx, rt_idx, rd_idx;
  logic [Data_Width-1:0]     sign_imm;
  logic [2:0]                alu_ctrl;
  logic                      funct_ok, op_legal;

  assign op       = ir[31:26];
  assign rs_idx   = Reg_Addr_Width'(ir[25:21]);
  assign rt_idx   = Reg_Addr_Width'(ir[20:16]);
  assign rd_idx   = Reg_Addr_Width'(ir[15:11]);
  assign sign_imm = {{(Data_Width-16){ir[15]}}, ir[15:0]};

  function automatic logic [Data_Width-1:0] alu(input logic [Data_Width-1:0] x,
                                                input logic [Data_Width-1:0] y,
                                                input logic [2:0] ctrl);
    case (ctrl)
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_SUB: return x - y;
      ALU_SLT: return {{(Data_Width-1){1'b0}}, ($signed(x) < $signed(y))};
      default: return x + y;
    endcase
  endfunction

  always_comb begin
    alu_ctrl = ALU_ADD;
    funct_ok = 1'b1;
    op_legal = 1'b0;
    case (ir[5:0])
      6'h20:   alu_ctrl = ALU_ADD;
      6'h22:   alu_ctrl = ALU_SUB;
      6'h24:   alu_ctrl = ALU_AND;
      6'h25:   alu_ctrl = ALU_OR;
      6'h2A:   alu_ctrl = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
    case (op)
      OP_RTYPE:                             op_legal = funct_ok;
      OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J:  op_legal = 1'b1;
      default:                              op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_FETCH;
      pc      <= Reset_Vector;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_out <= '0;
      mdr     <= '0;
      retired <= '0;
      for (int i = 0; i < 2**Reg_Addr_Width; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (Mem_Ready) begin
          ir    <= Mem_RData[31:0];
          pc    <= pc + Data_Width'(4);
          state <= S_DECODE;
        end
        // pc already holds PC+4 here, so alu_out becomes the branch target.
        S_DECODE: begin
          a_q     <= rf[rs_idx];
          b_q     <= rf[rt_idx];
          alu_out <= pc + (sign_imm << 2);
          if (!op_legal) begin
            retired <= retired + Count_Width'(1);
            state   <= S_FETCH;
          end else begin
            case (op)
              OP_LW, OP_SW: state <= S_MEMADR;
              OP_RTYPE:     state <= S_EXEC;
              OP_ADDI:      state <= S_ADDIEX;
              OP_BEQ:       state <= S_BRANCH;
              default:      state <= S_JUMP;
            endcase
          end
        end
        S_MEMADR: begin
          alu_out <= a_q + sign_imm;
          state   <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: if (Mem_Ready) begin
          mdr   <= Mem_RData;
          state <= S_MEMWB;
        end
        S_MEMWB: begin
          if (rt_idx != '0) rf[rt_idx] <= mdr;
          retired <= retired + Count_Width'(1);
          state   <= S_FETCH;
        end
        S_MEMWR: if (Mem_Ready) begin
          retired <= retired + Count_Width'(1);
          state   <= S_FETCH;
        end
        S_EXEC: begin
          alu_out <= alu(a_q, b_q, alu_ctrl);
          state   <= S_ALUWB;
        end
        S_ALUWB: begin
          if (rd_idx != '0) rf[rd_idx] <= alu_out;
          retired <= retired + Count_Width'(1);
          state   <= S_FETCH;
        end
        S_ADDIEX: begin
          alu_out <= a_q + sign_imm;
          state   <= S_ADDIWB;
        end
        S_ADDIWB: begin
          if (rt_idx != '0) rf[rt_idx] <= alu_out;
          retired <= retired + Count_Width'(1);
          state   <= S_FETCH;
        end
        S_BRANCH: begin
          if (alu(a_q, b_q, ALU_SUB) == '0) pc <= alu_out;
          retired <= retired + Count_Width'(1);
          state   <= S_FETCH;
        end
        S_JUMP: begin
          pc      <= {pc[Data_Width-1:28], ir[25:0], 2'b00};
          retired <= retired + Count_Width'(1);
          state   <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  // Memory handshake: Mem_Req holds Mem_WE/Mem_Addr/Mem_WData stable until a
  // cycle with Mem_Req & Mem_Ready, which completes the access; Ready alone is ignored.
  assign Mem_Req       = !RST && (state == S_FETCH || state == S_MEMRD || state == S_MEMWR);
  assign Mem_WE        = (state == S_MEMWR);
  assign Mem_Addr      = (state == S_FETCH) ? pc : alu_out;
  assign Mem_WData     = b_q;
  assign Illegal_Op    = !RST && (state == S_DECODE) && !op_legal;
  assign Instr_Retired = retired;
  assign dbg_state     = state;

endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Parametrised multicycle successor to the single-cycle datapath. It implements the MIPS subset lw, sw, R-type (add/sub/and/or/slt), addi, beq and j over one shared instruction/data memory port with a req/ready handshake. An internal control FSM sequences each instruction over 3–5 cycles, plus any memory wait states. The block sits between the top level and a unified memory model, replacing the separate datapath, controller and instruction/data memories of the single-cycle build.

## Interface
- Data_Width, 32: register/ALU/address width; must be ≥ 32. Instruction word is always Mem_RData[31:0].
- Reg_Addr_Width, 5: register-file address width. Register count is 2^Reg_Addr_Width, but only 32 are encodable by the instruction.
- Reset_Vector, 0: PC value after reset.
- Count_Width, 32: width of the retired-instruction counter.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- Mem_Req  out  1  memory access request; held until the handshake completes.
- Mem_WE  out  1  1 = write, 0 = read; valid while Mem_Req = 1.
- Mem_Addr  out  Data_Width  byte address; word-aligned.
- Mem_WData  out  Data_Width  store data; valid while Mem_Req & Mem_WE.
- Mem_RData  in  Data_Width  read data; sampled in the cycle Mem_Ready = 1.
- Mem_Ready  in  1  memory completes the access this cycle.
- Instr_Retired  out  Count_Width  count of completed instructions; wraps modulo 2^Count_Width.
- Illegal_Op  out  1  one-cycle pulse in DECODE for an unsupported opcode/funct.

## Operation
- Architectural state: PC, IR, register file, A/B latches, ALUOut, MDR.
- Register 0 always reads 0. Writes to register 0 are discarded.
- ALUControl encoding is 010 add, 110 sub, 000 and, 001 or, 111 slt (signed). Zero = (result == 0).
- SignImm is IR[15:0] sign-extended to Data_Width.
- Branch target = PC+4 + (SignImm<<2), modulo 2^Data_Width.
- Jump target = {PC+4[Data_Width-1:28], IR[25:0], 2'b00}.

FSM states and transitions:
- FETCH: Mem_Req=1, WE=0, Addr=PC. On Mem_Ready: IR ← Mem_RData[31:0], PC ← PC+4, go to DECODE. Otherwise stay in FETCH.
- DECODE: A ← RF[rs], B ← RF[rt], ALUOut ← branch target. Next state by opcode:
  - lw/sw → MEMADR
  - R-type → EXEC
  - addi → ADDIEX
  - beq → BRANCH
  - j → JUMP
  - anything else → FETCH with Illegal_Op=1; counted as retired, treated as a NOP.
- MEMADR: ALUOut ← A + SignImm. lw → MEMRD; sw → MEMWR.
- MEMRD: Req, WE=0, Addr=ALUOut. On Ready: MDR ← Mem_RData, go to MEMWB.
- MEMWB: RF[rt] ← MDR, go to FETCH.
- MEMWR: Req, WE=1, Addr=ALUOut, WData=B. On Ready go to FETCH.
- EXEC: ALUOut ← A op B (op from funct), go to ALUWB.
- ALUWB: RF[rd] ← ALUOut, go to FETCH.
- ADDIEX: ALUOut ← A + SignImm, go to ADDIWB.
- ADDIWB: RF[rt] ← ALUOut, go to FETCH.
- BRANCH: if A − B == 0 then PC ← ALUOut; go to FETCH.
- JUMP: PC ← jump target, go to FETCH.
- Instr_Retired increments by 1 on the clock edge that leaves any terminal state into FETCH. Terminal states: MEMWB, MEMWR-on-Ready, ALUWB, ADDIWB, BRANCH, JUMP, illegal DECODE.
- Mem_Req is asserted only in FETCH, MEMRD and MEMWR. Mem_Addr, Mem_WE and Mem_WData stay stable until Ready.

## Timing
- Reset (RST high at an edge):
  - state = FETCH, PC = Reset_Vector, all registers and latches = 0, Instr_Retired = 0.
  - Outputs: Mem_Req = 0 and Illegal_Op = 0 during the reset cycle.
  - First Mem_Req = 1 in the cycle after RST deasserts.
- RST mid-access: the pending access is abandoned and no register or PC update occurs. Memory must tolerate Req dropping without Ready.
- Latency with zero-wait memory (Ready in the first Req cycle): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles, illegal 2.
- Each memory wait cycle adds 1 cycle.
- Mem_Ready while Mem_Req = 0 is ignored.
- A write to register 0 completes the cycle count normally; the register still reads 0.
- PC wraps modulo 2^Data_Width.
- slt is a signed compare. Arithmetic overflow is ignored (no trap).

## Test plan
- Reset: hold RST 2 cycles → Mem_Addr = 0x0, Mem_Req = 0, Instr_Retired = 0. First fetch of address 0 occurs in the next cycle.
- addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1, zero-wait memory:
  - $3 = 2, $4 = 1.
  - Instr_Retired = 4 after 16 cycles.
- sw $3,8($0) then lw $5,8($0), with 3 wait states on every access:
  - Mem_WData = 2 at address 8; $5 = 2.
  - Addr/WE/WData stable across the wait cycles.
  - Total 4+3+3 + 5+3+3 = 21 cycles.
- beq $1,$1,+2 at PC 0x10 → next fetch at 0x1C. beq $1,$2,+2 (not equal) → next fetch at 0x14.
- j 0x40 (IR[25:0] = 0x10) at PC 0x20 → next fetch at 0x40; retired count +1 after 3 cycles.
- Illegal opcode 0x3F → Illegal_Op pulses once, no register write, next fetch at PC+4. RST asserted during a waiting lw MEMRD → destination register unchanged, PC = Reset_Vector.
